// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one transaction at a time. Define MEM_TIMEOUT_EN to abort stalled accesses.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_func,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  state_t     state, state_n;
  logic       owner_d;
  logic [1:0] fair_cnt;
  logic       fetch_owed;
  logic       active;
  logic       timeout;

  assign fetch_owed = (fair_cnt == 2'd2);
  assign active     = (state == FETCH) || (state == DATA);
  assign mem_req    = active;
  assign busy       = (state != IDLE);
  assign if_rvalid  = (state == RESP) && !owner_d;
  assign d_rvalid   = (state == RESP) && owner_d;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          err_q;

  assign timeout = active && !mem_ready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err     = (state == RESP) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE) to_cnt <= '0;
      else if (active)   to_cnt <= to_cnt + 1'b1;
      if (active) err_q <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    state_n = state;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (d_req && !(fetch_owed && if_req)) begin
            d_gnt   = 1'b1;
            state_n = DATA;
          end else if (if_req) begin
            if_gnt  = 1'b1;
            state_n = FETCH;
          end
        end
      end
      FETCH, DATA: if (mem_ready || timeout) state_n = RESP;
      RESP:        state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d   <= 1'b0;
      mem_we    <= 1'b0;
      mem_func  <= 3'b000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      fair_cnt  <= 2'd0;
    end else begin
      if (d_gnt) begin
        owner_d   <= 1'b1;
        mem_we    <= d_we;
        mem_func  <= d_func;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        // Only back-to-back D wins against a waiting fetch build up debt.
        fair_cnt  <= if_req ? fair_cnt + 2'd1 : 2'd0;
      end else if (if_gnt) begin
        owner_d   <= 1'b0;
        mem_we    <= 1'b0;
        mem_func  <= 3'b010;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        fair_cnt  <= 2'd0;
      end
      if (active && (mem_ready || timeout)) begin
        if (owner_d) d_rdata  <= timeout ? '0 : mem_rdata;
        else         if_rdata <= timeout ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, contention, fairness,
// store and timeout (or indefinite wait when MEM_TIMEOUT_EN is undefined).
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [2:0]  d_func, mem_func;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, busy, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_func(d_func), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_func(mem_func),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, then
  // outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_func = 0;
    d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rdata = 0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_err", err, 0);
    #10 rst_n = 1'b1;
    cyc();

    // Fetch: grant N, ready in N+3, rvalid in N+4
    if_req = 1; if_addr = 32'h100; #1;
    chk("fetch_if_gnt", if_gnt, 1);
    chk("fetch_d_gnt", d_gnt, 0);
    cyc(); if_req = 0; #1;
    chk("fetch_mem_req", mem_req, 1);
    chk("fetch_mem_addr", mem_addr, 32'h100);
    chk("fetch_mem_we", mem_we, 0);
    chk("fetch_mem_func", mem_func, 3'b010);
    chk("fetch_busy", busy, 1);
    cyc();
    chk("fetch_wait", mem_req, 1);
    cyc(); mem_ready = 1; mem_rdata = 32'h13;
    cyc(); mem_ready = 0; mem_rdata = 0; #1;
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 32'h13);
    chk("fetch_req_drop", mem_req, 0);
    cyc();
    chk("fetch_rvalid_pulse", if_rvalid, 0);
    chk("fetch_idle", busy, 0);
    chk("fetch_rdata_hold", if_rdata, 32'h13);

    // Contention: D wins, IF granted the cycle after d_rvalid
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 0; d_func = 3'b010; d_addr = 32'h2000; #1;
    chk("cont_d_gnt", d_gnt, 1);
    chk("cont_if_gnt0", if_gnt, 0);
    cyc(); d_req = 0; #1;
    chk("cont_mem_addr", mem_addr, 32'h2000);
    chk("cont_if_gnt1", if_gnt, 0);
    mem_ready = 1; mem_rdata = 32'h55AA;
    cyc(); mem_ready = 0; #1;
    chk("cont_d_rvalid", d_rvalid, 1);
    chk("cont_d_rdata", d_rdata, 32'h55AA);
    chk("cont_if_gnt2", if_gnt, 0);
    cyc();
    chk("cont_if_gnt3", if_gnt, 1);
    cyc(); if_req = 0; mem_ready = 1; mem_rdata = 32'h77;
    cyc(); mem_ready = 0; #1;
    chk("cont_if_rvalid", if_rvalid, 1);
    chk("cont_if_rdata", if_rdata, 32'h77);
    cyc();

    // Fairness: both held -> D, D, IF, D, D, IF
    if_req = 1; d_req = 1; d_addr = 32'h2100;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("fair_d_gnt%0d", i), d_gnt, (i % 3 == 2) ? 0 : 1);
      chk($sformatf("fair_if_gnt%0d", i), if_gnt, (i % 3 == 2) ? 1 : 0);
      cyc(); mem_ready = 1;
      cyc(); mem_ready = 0;
      cyc();
    end
    if_req = 0; d_req = 0;

    // Store
    d_req = 1; d_we = 1; d_func = 3'b010; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF; #1;
    chk("st_d_gnt", d_gnt, 1);
    cyc(); d_req = 0; #1;
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_mem_func", mem_func, 3'b010);
    mem_ready = 1; mem_rdata = 32'h1234;
    cyc(); mem_ready = 0; mem_rdata = 0; #1;
    chk("st_d_rvalid", d_rvalid, 1);
    chk("st_d_rdata", d_rdata, 32'h1234);
    cyc();
    chk("st_idle", busy, 0);
    d_we = 0;

    // Timeout (or indefinite wait)
    d_req = 1; d_addr = 32'h4000; #1;
    chk("to_d_gnt", d_gnt, 1);
    cyc(); d_req = 0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("to_req%0d", i), mem_req, 1);
      cyc();
    end
    #1;
    chk("to_req_drop", mem_req, 0);
    chk("to_d_rvalid", d_rvalid, 1);
    chk("to_err", err, 1);
    chk("to_d_rdata", d_rdata, 0);
    cyc();
    chk("to_busy", busy, 0);
    chk("to_err_pulse", err, 0);
`else
    repeat (10) cyc();
    chk("wait_req", mem_req, 1);
    chk("wait_err", err, 0);
    chk("wait_busy", busy, 1);
    mem_ready = 1; mem_rdata = 32'h99;
    cyc(); mem_ready = 0; #1;
    chk("wait_d_rvalid", d_rvalid, 1);
    chk("wait_d_rdata", d_rdata, 32'h99);
    cyc();
`endif

    // Reset in DATA drops mem_req immediately
    d_req = 1; d_addr = 32'h5000; #1;
    chk("rst2_d_gnt", d_gnt, 1);
    cyc(); d_req = 0; #1;
    chk("rst2_req_before", mem_req, 1);
    #1 rst_n = 1'b0; #1;
    chk("rst2_mem_req", mem_req, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_d_rdata", d_rdata, 0);
    chk("rst2_mem_addr", mem_addr, 0);
    #10 rst_n = 1'b1;
    cyc();
    chk("rst2_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
